// File: rtl/cas_key_loader.sv
// cas_key_loader: serial CAS-Lock key loader. Bits are shifted into a hidden
// shadow register, parity-checked, and only then committed to the key bus.
// Too many consecutive parity failures lock the bus at zero until reset.
module cas_key_loader #(
   parameter int KEY_WIDTH = 64,
   parameter int MAX_FAIL  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_start,
   input  logic                 key_clear,
   input  logic                 key_bit,
   input  logic                 key_bit_valid,
   output logic                 key_bit_ready,
   output logic [KEY_WIDTH-1:0] key_out,
   output logic                 key_valid,
   output logic                 busy,
   output logic                 err,
   output logic                 locked_out
);

   localparam int CNT_W  = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
   localparam int FAIL_W = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      PARITY  = 3'd2,
      COMMIT  = 3'd3,
      LOCKOUT = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [FAIL_W-1:0]    fail_q, fail_d;
   logic [FAIL_W-1:0]    fail_inc;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic                 kvalid_q, kvalid_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic                 locked_q, locked_d;
   logic                 accept;

   // A bit transfers only when the registered ready is already high.
   assign accept   = key_bit_valid & ready_q;
   assign fail_inc = fail_q + 1'b1;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      count_d  = count_q;
      fail_d   = fail_q;
      key_d    = key_q;
      kvalid_d = kvalid_q;
      err_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d  = SHIFT;
               count_d  = '0;
               shadow_d = '0;
            end
         end
         SHIFT: begin
            if (load_start) begin
               // Restart: the bit offered this cycle is dropped.
               count_d  = '0;
               shadow_d = '0;
            end else if (accept) begin
               shadow_d[count_q] = key_bit;
               if (count_q == CNT_W'(KEY_WIDTH - 1)) begin
                  state_d = PARITY;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (load_start) begin
               state_d  = SHIFT;
               count_d  = '0;
               shadow_d = '0;
            end else if (accept) begin
               if (((^shadow_q) ^ key_bit) == 1'b0) begin
                  state_d = COMMIT;
               end else begin
                  err_d  = 1'b1;
                  fail_d = fail_inc;
                  if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                     state_d  = LOCKOUT;
                     shadow_d = '0;
                     key_d    = '0;
                     kvalid_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         COMMIT: begin
            // Single-cycle atomic update of the live key; load_start is ignored.
            key_d    = shadow_q;
            kvalid_d = 1'b1;
            fail_d   = '0;
            state_d  = IDLE;
         end
         LOCKOUT: begin
            shadow_d = '0;
            key_d    = '0;
            kvalid_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Zeroise overrides a same-edge commit; it has no effect once locked.
      if (key_clear && (state_q != LOCKOUT)) begin
         key_d    = '0;
         kvalid_d = 1'b0;
      end

      // Status outputs are registered from the next state so they track state_q.
      ready_d  = (state_d == SHIFT) || (state_d == PARITY);
      busy_d   = (state_d == SHIFT) || (state_d == PARITY) || (state_d == COMMIT);
      locked_d = (state_d == LOCKOUT);
   end

   // State, shadow, counters and all outputs, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         count_q  <= '0;
         fail_q   <= '0;
         key_q    <= '0;
         kvalid_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         count_q  <= count_d;
         fail_q   <= fail_d;
         key_q    <= key_d;
         kvalid_q <= kvalid_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         locked_q <= locked_d;
      end
   end

   assign key_bit_ready = ready_q;
   assign key_out       = key_q;
   assign key_valid     = kvalid_q;
   assign busy          = busy_q;
   assign err           = err_q;
   assign locked_out    = locked_q;

endmodule
